// File: rtl/adc_cfg_pkg.sv
// Shared definitions for the ADC command arbiter: FSM encoding and status word layout.
package adc_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_SETTLE    = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int unsigned STAT_CNT_W        = 16;
    localparam int unsigned STAT_PEND_BIT     = 16;
    localparam int unsigned STAT_STATE_LSB    = 17;
    localparam int unsigned STAT_HOSTWAIT_BIT = 19;

    function automatic logic [31:0] pack_status(
        input logic [STAT_CNT_W-1:0] i_cnt,
        input logic                  i_pend,
        input arb_state_e            i_state,
        input logic                  i_host_wait
    );
        logic [31:0] w_s;
        w_s                        = '0;
        w_s[STAT_CNT_W-1:0]        = i_cnt;
        w_s[STAT_PEND_BIT]         = i_pend;
        w_s[STAT_STATE_LSB +: 2]   = i_state;
        w_s[STAT_HOSTWAIT_BIT]     = i_host_wait;
        return w_s;
    endfunction

endpackage

// File: rtl/adc_trig_latch.sv
// Conversion-request latch with saturating dropped-trigger counter.
module adc_trig_latch #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             i_enable,
    input  logic             i_trigger,
    input  logic             i_clear_cnt,
    input  logic             i_grant,
    output logic             o_pending,
    output logic [CNT_W-1:0] o_drop_cnt
);

    logic             r_pending;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             w_drop;

    // A trigger landing on the grant cycle re-arms the latch instead of counting as a drop.
    assign w_drop = i_enable & i_trigger & r_pending & ~i_grant;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pending <= 1'b0;
        end else if (!i_enable) begin
            r_pending <= 1'b0;
        end else if (i_trigger) begin
            r_pending <= 1'b1;
        end else if (i_grant) begin
            r_pending <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_drop_cnt <= '0;
        end else if (i_clear_cnt) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    assign o_pending  = r_pending;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: rtl/adc_cmd_arbiter.sv
// Arbitrates ADC conversion commands against a host command stream toward the SPI engine,
// with bounded starvation of the host.
module adc_cmd_arbiter
    import adc_cfg_pkg::*;
#(
    parameter int unsigned DW           = 32,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          enable,
    input  logic          trigger,
    input  logic [DW-1:0] conv_cmd,
    input  logic          clear_cnt,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    input  logic          adc_busy,
    output logic [31:0]   status
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e       r_state;
    arb_state_e       w_state_next;
    logic             r_armed;
    logic [SW-1:0]    r_starve;
    logic [DW-1:0]    r_m_tdata;
    logic             r_m_tvalid;
    logic [31:0]      r_status;

    logic             w_pending;
    logic [CNT_W-1:0] w_drop_cnt;
    logic             w_conv_win;
    logic             w_host_win;

    adc_trig_latch #(
        .CNT_W (CNT_W)
    ) u_trig_latch (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_enable    (enable),
        .i_trigger   (trigger),
        .i_clear_cnt (clear_cnt),
        .i_grant     (w_conv_win),
        .o_pending   (w_pending),
        .o_drop_cnt  (w_drop_cnt)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_conv_win || w_host_win) w_state_next = ST_ISSUE;
            ST_ISSUE:     if (m_axis_tready)            w_state_next = ST_SETTLE;
            ST_SETTLE:                                  w_state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!adc_busy)                w_state_next = ST_IDLE;
            default:                                    w_state_next = ST_IDLE;
        endcase
    end

    // r_armed holds off grants for the first edge after reset release.
    always_comb begin
        w_conv_win = 1'b0;
        w_host_win = 1'b0;
        if ((r_state == ST_IDLE) && r_armed) begin
            w_conv_win = w_pending && (!s_axis_tvalid || (r_starve < SW'(STARVE_LIMIT)));
            w_host_win = !w_conv_win && s_axis_tvalid;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_armed    <= 1'b0;
            r_starve   <= '0;
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_status   <= '0;
        end else begin
            r_armed    <= 1'b1;
            r_m_tvalid <= (w_state_next == ST_ISSUE);
            if (w_conv_win) begin
                r_m_tdata <= conv_cmd;
            end else if (w_host_win) begin
                r_m_tdata <= s_axis_tdata;
            end
            if (w_host_win) begin
                r_starve <= '0;
            end else if (w_conv_win && s_axis_tvalid) begin
                r_starve <= r_starve + SW'(1);
            end
            r_status <= pack_status(16'(w_drop_cnt), w_pending, r_state,
                                    s_axis_tvalid && !w_host_win);
        end
    end

    assign s_axis_tready = w_host_win;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign status        = r_status;

endmodule

// File: doc/adc_cmd_arbiter.md
ADC_CMD_ARBITER -- requirements
Module: adc_cmd_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, command word width.
REQ-002 SHALL have parameter CNT_W, default 16, dropped-trigger counter width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, maximum consecutive conversion grants while host waits.
REQ-004 SHALL have port aclk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  conversion path enable.
REQ-007 SHALL have port trigger  input  1  single-cycle conversion request pulse.
REQ-008 SHALL have port conv_cmd  input  DW  command word issued per conversion.
REQ-009 SHALL have port clear_cnt  input  1  pulse, clears drop counter.
REQ-010 SHALL have ports s_axis_tdata/tvalid/tready  in/in/out  DW/1/1  host command stream.
REQ-011 SHALL have ports m_axis_tdata/tvalid/tready  out/out/in  DW/1/1  command stream to ADC SPI engine.
REQ-012 SHALL have port adc_busy  input  1  SPI engine transaction in progress.
REQ-013 SHALL have port status  output  32  [CNT_W-1:0] drop count, [16] conv pending, [18:17] state, [19] host waiting.

Function
REQ-014 SHALL implement states IDLE, ISSUE, SETTLE, WAIT_DONE.
REQ-015 trigger with enable=1 SHALL set conv_pending next cycle; trigger while conv_pending already set SHALL increment drop count, saturating at all-ones.
REQ-016 enable=0 SHALL clear conv_pending next cycle; triggers then SHALL be ignored and not counted.
REQ-017 clear_cnt SHALL zero drop count next cycle; clear_cnt coincident with a drop SHALL yield count 0.
REQ-018 In IDLE, if conv_pending and (no host tvalid or starve count < STARVE_LIMIT), SHALL grant conversion: latch conv_cmd into m_axis_tdata, clear conv_pending, increment starve count if s_axis_tvalid, go ISSUE.
REQ-019 In IDLE, otherwise if s_axis_tvalid, SHALL assert s_axis_tready for that cycle only, latch s_axis_tdata, reset starve count to 0, go ISSUE.
REQ-020 s_axis_tready SHALL be 0 in every state other than IDLE and in IDLE when conversion wins.
REQ-021 trigger arriving in the same cycle conv_pending is cleared by a grant SHALL set conv_pending again (not a drop).
REQ-022 In ISSUE, m_axis_tvalid SHALL be 1 and m_axis_tdata stable until m_axis_tready; on handshake go SETTLE.
REQ-023 SETTLE SHALL last exactly one cycle, then go WAIT_DONE (allows adc_busy to assert).
REQ-024 In WAIT_DONE, SHALL return to IDLE on first cycle adc_busy=0.
REQ-025 Minimum grant-to-grant spacing SHALL be 4 cycles (IDLE, ISSUE with immediate tready, SETTLE, WAIT_DONE).
REQ-026 m_axis_tvalid and m_axis_tdata SHALL be registered outputs.
REQ-027 status SHALL be registered, one cycle latency from internal state; unused bits 0.
REQ-028 With no host traffic, conversions SHALL be granted without limit; starve count SHALL only advance while host waits.

Reset
REQ-029 aresetn low SHALL immediately force state IDLE, m_axis_tvalid 0, m_axis_tdata 0, s_axis_tready 0, status 0, conv_pending 0, drop count 0, starve count 0.
REQ-030 Reset mid-ISSUE SHALL drop the in-flight command without handshake; no replay after release.
REQ-031 First grant possible on second rising edge after aresetn release.

Structure
REQ-032 State encoding (2 bits) and status bit positions SHALL live in shared package adc_cfg_pkg.
REQ-033 Trigger latch, drop counter and clear logic SHALL be sub-module adc_trig_latch; arbitration FSM in top.

Verification
REQ-034 Host writes 0xA5A5_0001, no trigger, tready=1, adc_busy high 3 cycles after SETTLE -> one m_axis beat 0xA5A5_0001, s_axis_tready one cycle, next grant no earlier than adc_busy fall.
REQ-035 enable=1, conv_cmd 0x0000_00C3, trigger every 10 cycles, adc_busy 2 cycles -> one 0xC3 beat per trigger, drop count 0.
REQ-036 Three triggers while m_axis_tready held 0 for 50 cycles -> first issued, second pending, third counted: status[15:0]=1, status[16]=1.
REQ-037 Host tvalid held continuously plus trigger every cycle -> host beat granted after exactly 4 conversion beats, repeating 4:1.
REQ-038 Drop count forced to 0xFFFF by repeated drops, further drops -> stays 0xFFFF; clear_cnt with a drop same cycle -> 0.
REQ-039 aresetn pulsed low during ISSUE -> m_axis_tvalid 0 asynchronously, status 0, no beat after release until new request.
